// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, trap causes, csr_op encodings, SYSTEM encodings, FSM states
package csr_pkg;
    localparam logic [11:0] CSR_FFLAGS   = 12'h001;
    localparam logic [11:0] CSR_FRM      = 12'h002;
    localparam logic [11:0] CSR_FCSR     = 12'h003;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam int unsigned CAUSE_FETCH   = 0;
    localparam int unsigned CAUSE_ILLEGAL = 2;
    localparam int unsigned CAUSE_BREAK   = 3;
    localparam int unsigned CAUSE_LOAD    = 4;
    localparam int unsigned CAUSE_STORE   = 6;
    localparam int unsigned CAUSE_ECALL   = 11;
    localparam int unsigned IRQ_BASE      = 16;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    localparam logic [6:0] OPC_LOAD  = 7'd3;
    localparam logic [6:0] OPC_STORE = 7'd35;

    typedef enum logic [1:0] {CSR_NONE, CSR_WRITE, CSR_SET, CSR_CLEAR} csr_op_e;
    typedef enum logic {ST_RUN, ST_REDIRECT} state_e;

    function automatic logic legal_opcode(input logic [6:0] opc);
        return opc inside {7'd3, 7'd19, 7'd35, 7'd51, 7'd99, 7'd111, 7'd115};
    endfunction
endpackage

// File: rtl/csr_trap_unit_if.sv
// csr_trap_unit_if: execute-stage bundle into the CSR/trap unit
//   master drives instr, pc, ram_addr, retire, csr_op, csr, wd, irq
//   slave  drives rd (CSR read data), op_m/addr_o (PC redirect)
interface csr_trap_unit_if #(parameter int XLEN = 32, parameter int NUM_IRQ = 4);
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic [15:0]      ram_addr;
    logic             retire;
    logic [1:0]       csr_op;
    logic [11:0]      csr;
    logic [XLEN-1:0]  wd;
    logic [XLEN-1:0]  rd;
    logic [NUM_IRQ-1:0] irq;
    logic [1:0]       op_m;
    logic [XLEN-1:0]  addr_o;

    modport master (output instr, pc, ram_addr, retire, csr_op, csr, wd, irq,
                    input rd, op_m, addr_o);
    modport slave  (input instr, pc, ram_addr, retire, csr_op, csr, wd, irq,
                    output rd, op_m, addr_o);
endinterface

// File: rtl/csr_irq_prio.sv
// csr_irq_prio: masks pending by enabled interrupts and picks the lowest index
//   pend/en: per-line pending and enable bits; valid: any enabled pending; idx: winner
module csr_irq_prio #(parameter int NUM_IRQ = 4) (
    input  logic [NUM_IRQ-1:0] pend,
    input  logic [NUM_IRQ-1:0] en,
    output logic               valid,
    output logic [3:0]         idx
);
    logic [NUM_IRQ-1:0] act;
    assign act = pend & en;
    always_comb begin
        valid = |act;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (act[i]) idx = 4'(i);
    end
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine CSR file with trap/MRET control and a registered PC redirect
//   clk/rst: clock and async active-high reset
//   bus (slave): instruction/CSR access in, rd read data and op_m/addr_o redirect out
module csr_trap_unit import csr_pkg::*; #(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 4,
    parameter int              ROM_LIMIT   = 100,
    parameter int              RAM_LIMIT   = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input logic clk,
    input logic rst,
    csr_trap_unit_if.slave bus
);
    logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mcycle, minstret, target;
    logic [XLEN-1:0] rd_val, wval, cause, trap_tgt, base, mip_full;
    logic [7:0] fcsr;
    logic [NUM_IRQ-1:0] mip;
    logic [6:0] opc;
    logic [3:0] irq_idx;
    logic run, bad_pc, illegal, ebreak, ecall, ls_fault, irq_valid, irq_take, exc, trap, mret, wr_en;
    state_e state, state_n;

    csr_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .pend(mip), .en(mie[IRQ_BASE +: NUM_IRQ]), .valid(irq_valid), .idx(irq_idx)
    );

    assign mip_full = XLEN'(mip) << IRQ_BASE;
    assign base = {mtvec[XLEN-1:2], 2'b00};

    // Detection is suppressed while redirecting: the instruction on the bus is being flushed.
    always_comb begin
        opc = bus.instr[6:0];
        run = state == ST_RUN;
        bad_pc = bus.pc > XLEN'(ROM_LIMIT);
        illegal = !legal_opcode(opc);
        ebreak = bus.instr == INSTR_EBREAK;
        ecall = bus.instr == INSTR_ECALL;
        ls_fault = (opc == OPC_LOAD || opc == OPC_STORE) && bus.ram_addr > 16'(RAM_LIMIT);
        irq_take = mstatus[MIE_BIT] && irq_valid;
        exc = bad_pc || illegal || ebreak || ecall || ls_fault;
        trap = run && (exc || irq_take);
        mret = run && !trap && bus.instr == INSTR_MRET;
        cause = bad_pc  ? XLEN'(CAUSE_FETCH) :
                illegal ? XLEN'(CAUSE_ILLEGAL) :
                ebreak  ? XLEN'(CAUSE_BREAK) :
                ecall   ? XLEN'(CAUSE_ECALL) :
                ls_fault ? XLEN'(opc == OPC_LOAD ? CAUSE_LOAD : CAUSE_STORE) :
                {1'b1, (XLEN-1)'(IRQ_BASE + irq_idx)};
        trap_tgt = (mtvec[1:0] == 2'b01 && !exc) ? base + XLEN'(4 * (IRQ_BASE + irq_idx)) : base;
    end

    always_comb begin
        case (bus.csr)
            CSR_FFLAGS:   rd_val = XLEN'(fcsr[4:0]);
            CSR_FRM:      rd_val = XLEN'(fcsr[7:5]);
            CSR_FCSR:     rd_val = XLEN'(fcsr);
            CSR_MSTATUS:  rd_val = mstatus;
            CSR_MIE:      rd_val = mie;
            CSR_MTVEC:    rd_val = mtvec;
            CSR_MSCRATCH: rd_val = mscratch;
            CSR_MEPC:     rd_val = mepc;
            CSR_MCAUSE:   rd_val = mcause;
            CSR_MIP:      rd_val = mip_full;
            CSR_MCYCLE:   rd_val = mcycle;
            CSR_MINSTRET: rd_val = minstret;
            default:      rd_val = '0;
        endcase
        wval = bus.csr_op == CSR_WRITE ? bus.wd :
               bus.csr_op == CSR_SET   ? rd_val | bus.wd : rd_val & ~bus.wd;
        wr_en = bus.csr_op != CSR_NONE && !trap && !(mret && bus.csr == CSR_MSTATUS);
    end

    assign bus.rd = rd_val;

    // Trap/MRET updates come after the software write so they take precedence bit by bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {mstatus, mie, mscratch, mepc, mcause, mcycle, minstret, target} <= '0;
            mtvec <= MTVEC_RESET;
            fcsr <= '0;
            mip <= '0;
        end else begin
            mip <= bus.irq;
            mcycle <= (wr_en && bus.csr == CSR_MCYCLE) ? wval : mcycle + XLEN'(1);
            minstret <= (wr_en && bus.csr == CSR_MINSTRET) ? wval : minstret + XLEN'(bus.retire && !trap);
            if (wr_en)
                case (bus.csr)
                    CSR_FFLAGS:   fcsr[4:0] <= wval[4:0];
                    CSR_FRM:      fcsr[7:5] <= wval[2:0];
                    CSR_FCSR:     fcsr <= wval[7:0];
                    CSR_MSTATUS:  mstatus <= wval;
                    CSR_MIE:      mie <= wval;
                    CSR_MTVEC:    mtvec <= wval;
                    CSR_MSCRATCH: mscratch <= wval;
                    CSR_MEPC:     mepc <= wval;
                    CSR_MCAUSE:   mcause <= wval;
                    default: ;
                endcase
            if (trap) begin
                mepc <= bus.pc;
                mcause <= cause;
                mstatus[MPIE_BIT] <= mstatus[MIE_BIT];
                mstatus[MIE_BIT] <= 1'b0;
                target <= trap_tgt;
            end else if (mret) begin
                mstatus[MIE_BIT] <= mstatus[MPIE_BIT];
                mstatus[MPIE_BIT] <= 1'b1;
                target <= mepc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_RUN;
        else state <= state_n;

    always_comb state_n = (state == ST_RUN && (trap || mret)) ? ST_REDIRECT : ST_RUN;

    always_comb begin
        bus.op_m = state == ST_REDIRECT ? 2'b11 : 2'b00;
        bus.addr_o = state == ST_REDIRECT ? target : '0;
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed table-driven bench for csr_trap_unit
module tb_csr_trap_unit;
    import csr_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0] WR = 2'b01, SET = 2'b10, CLR = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] a;
        logic [31:0] wd;
        logic [31:0] erd;
        logic [1:0]  eop;
        logic [31:0] ead;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [15:0] ra;
        logic [3:0]  irq;
        logic        ret;
    } vec_t;

    logic clk, rst;
    int checks = 0, errors = 0;
    vec_t vq[$];

    csr_trap_unit_if #(.XLEN(32), .NUM_IRQ(4)) bus ();

    csr_trap_unit #(.MTVEC_RESET(32'h40)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic vec_t v(logic [1:0] op, logic [11:0] a, logic [31:0] wd, logic [31:0] erd,
                               logic [1:0] eop = 0, logic [31:0] ead = 0, logic [31:0] ins = NOP,
                               logic [31:0] pc = 32'h10, logic [15:0] ra = 0, logic [3:0] irq = 0,
                               logic ret = 0);
        vec_t r;
        r = '{op, a, wd, erd, eop, ead, ins, pc, ra, irq, ret};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        bus.csr_op = x.op; bus.csr = x.a; bus.wd = x.wd; bus.instr = x.ins;
        bus.pc = x.pc; bus.ram_addr = x.ra; bus.irq = x.irq; bus.retire = x.ret;
    endtask

    initial begin
        vq.push_back(v(0, CSR_MTVEC, 0, 32'h40));
        vq.push_back(v(0, CSR_MCYCLE, 0, 2));
        vq.push_back(v(0, CSR_MCYCLE, 0, 3));
        vq.push_back(v(SET, CSR_MIE, 32'h10000, 0));
        vq.push_back(v(0, CSR_MIE, 0, 32'h10000));
        vq.push_back(v(CLR, CSR_MIE, 32'h10000, 32'h10000));
        vq.push_back(v(0, CSR_MIE, 0, 0));
        vq.push_back(v(WR, CSR_MSTATUS, 8, 0));
        vq.push_back(v(0, CSR_MSTATUS, 0, 8, 0, 0, 32'hFFFF_FFFF, 32'h20, 0, 0, 1));
        vq.push_back(v(0, CSR_MEPC, 0, 32'h20, 3, 32'h40));
        vq.push_back(v(0, CSR_MCAUSE, 0, 2));
        vq.push_back(v(0, CSR_MSTATUS, 0, 32'h80));
        vq.push_back(v(0, CSR_MINSTRET, 0, 0, 0, 0, NOP, 32'h10, 0, 0, 1));
        vq.push_back(v(0, CSR_MINSTRET, 0, 1));
        vq.push_back(v(WR, CSR_MIE, 32'h30000, 0));
        vq.push_back(v(WR, CSR_MTVEC, 32'h81, 32'h40));
        vq.push_back(v(WR, CSR_MSTATUS, 8, 32'h80, 0, 0, NOP, 32'h10, 0, 4'b0011));
        vq.push_back(v(0, CSR_MIP, 0, 32'h30000, 0, 0, NOP, 32'h10, 0, 4'b0011));
        vq.push_back(v(0, CSR_MCAUSE, 0, 32'h8000_0010, 3, 32'hC0));
        vq.push_back(v(0, CSR_MSTATUS, 0, 32'h80, 0, 0, INSTR_MRET));
        vq.push_back(v(0, CSR_MSTATUS, 0, 32'h88, 3, 32'h10));
        vq.push_back(v(0, CSR_MEPC, 0, 32'h10));
        vq.push_back(v(WR, CSR_MSCRATCH, 32'h1234, 0, 0, 0, INSTR_ECALL, 32'h10, 0, 0, 1));
        vq.push_back(v(0, CSR_MSCRATCH, 0, 0, 3, 32'h80));
        vq.push_back(v(0, CSR_MCAUSE, 0, 11));
        vq.push_back(v(0, CSR_MINSTRET, 0, 1));
        vq.push_back(v(0, CSR_MIP, 0, 0, 0, 0, NOP, 32'h10, 0, 4'b0010));
        vq.push_back(v(0, CSR_MIP, 0, 32'h20000, 0, 0, NOP, 32'h10, 0, 4'b0010));
        vq.push_back(v(SET, CSR_MSTATUS, 8, 32'h80, 0, 0, NOP, 32'h10, 0, 4'b0010));
        vq.push_back(v(0, CSR_MSTATUS, 0, 32'h88, 0, 0, NOP, 32'h10, 0, 4'b0010));
        vq.push_back(v(0, CSR_MCAUSE, 0, 32'h8000_0011, 3, 32'hC4));
        vq.push_back(v(0, CSR_MCYCLE, 0, 32, 0, 0, NOP, 100));
        vq.push_back(v(0, CSR_MCAUSE, 0, 32'h8000_0011, 0, 0, NOP, 101));
        vq.push_back(v(0, CSR_MCAUSE, 0, 0, 3, 32'h80));
        vq.push_back(v(0, CSR_MEPC, 0, 101, 0, 0, 32'h3, 32'h10, 64));
        vq.push_back(v(0, CSR_MEPC, 0, 101, 0, 0, 32'h3, 32'h10, 65));
        vq.push_back(v(0, CSR_MCAUSE, 0, 4, 3, 32'h80));
        vq.push_back(v(0, CSR_MEPC, 0, 32'h10, 0, 0, 32'h23, 32'h10, 66));
        vq.push_back(v(0, CSR_MCAUSE, 0, 6, 3, 32'h80));
        vq.push_back(v(0, CSR_MCAUSE, 0, 6, 0, 0, INSTR_EBREAK));
        vq.push_back(v(0, CSR_MCAUSE, 0, 3, 3, 32'h80));
        vq.push_back(v(WR, 12'h7C0, 5, 0));
        vq.push_back(v(0, 12'h7C0, 0, 0));
        vq.push_back(v(WR, CSR_FCSR, 32'hFF, 0));
        vq.push_back(v(0, CSR_FRM, 0, 7));
        vq.push_back(v(0, CSR_FFLAGS, 0, 32'h1F));
        vq.push_back(v(CLR, CSR_FFLAGS, 1, 32'h1F));
        vq.push_back(v(0, CSR_FCSR, 0, 32'hFE));
        vq.push_back(v(WR, CSR_MCYCLE, 32'h100, 49));
        vq.push_back(v(0, CSR_MCYCLE, 0, 32'h100));
        vq.push_back(v(0, CSR_MCYCLE, 0, 32'h101));
        vq.push_back(v(WR, CSR_MINSTRET, 32'hFFFF_FFFF, 1, 0, 0, NOP, 32'h10, 0, 0, 1));
        vq.push_back(v(0, CSR_MINSTRET, 0, 32'hFFFF_FFFF, 0, 0, NOP, 32'h10, 0, 0, 1));
        vq.push_back(v(0, CSR_MINSTRET, 0, 0));

        rst = 1;
        drive(v(0, CSR_MTVEC, 0, 0));
        repeat (2) @(negedge clk);
        #1;
        check("reset op_m", 32'(bus.op_m), 0);
        check("reset addr_o", bus.addr_o, 0);
        check("reset mtvec", bus.rd, 32'h40);
        rst = 0;

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k]);
            #1;
            check($sformatf("v%0d rd", k), bus.rd, vq[k].erd);
            check($sformatf("v%0d op_m", k), 32'(bus.op_m), 32'(vq[k].eop));
            check($sformatf("v%0d addr_o", k), bus.addr_o, vq[k].ead);
        end

        // reset landing in the middle of a redirect
        @(negedge clk);
        drive(v(0, CSR_MTVEC, 0, 0, 0, 0, 32'hFFFF_FFFF));
        #1 check("pre-redirect op_m", 32'(bus.op_m), 0);
        @(negedge clk);
        drive(v(0, CSR_MTVEC, 0, 0));
        #1;
        check("redirect op_m", 32'(bus.op_m), 3);
        check("redirect addr_o", bus.addr_o, 32'h80);
        rst = 1;
        #1;
        check("mid-redirect rst op_m", 32'(bus.op_m), 0);
        check("mid-redirect rst addr_o", bus.addr_o, 0);
        check("rst mtvec", bus.rd, 32'h40);
        bus.csr = CSR_MCAUSE; #1 check("rst mcause", bus.rd, 0);
        bus.csr = CSR_MEPC; #1 check("rst mepc", bus.rd, 0);
        bus.csr = CSR_MSTATUS; #1 check("rst mstatus", bus.rd, 0);
        bus.csr = CSR_MIE; #1 check("rst mie", bus.rd, 0);
        bus.csr = CSR_MIP; #1 check("rst mip", bus.rd, 0);
        bus.csr = CSR_FCSR; #1 check("rst fcsr", bus.rd, 0);
        bus.csr = CSR_MINSTRET; #1 check("rst minstret", bus.rd, 0);
        bus.csr = CSR_MCYCLE; #1 check("rst mcycle", bus.rd, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        #1;
        check("post-rst mcycle", bus.rd, 1);
        check("post-rst op_m", 32'(bus.op_m), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Parametrised machine-mode CSR file and trap controller for the rv32i data path; successor to the single-channel exception CSR block. Holds the standard machine CSRs at their architectural addresses, supports CSRRW/CSRRS/CSRRC semantics, stacks MIE/MPIE on trap entry and MRET, and arbitrates synchronous exceptions against `NUM_IRQ` external interrupt lines. The PC-redirect request is registered, not combinational, so the fetch stage sees a clean one-cycle redirect pulse.

## Interface
- `XLEN`, 32: data width of all CSRs and of `wd`, `rd`, `pc`, `addr_o`.
- `NUM_IRQ`, 4: external interrupt lines, 1..16, mapped to `mip`/`mie` bits 16+i.
- `ROM_LIMIT`, 100: a `pc` above this raises cause 0.
- `RAM_LIMIT`, 64: a `ram_addr` above this, with a load/store opcode, raises cause 4 for loads and 6 for stores.
- `MTVEC_RESET`, 0: reset value of `mtvec`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: instruction in execute.
- `pc` in XLEN: address of `instr`.
- `ram_addr` in 16: data address of `instr`.
- `retire` in 1: `instr` completes this cycle.
- `csr_op` in 2: 00 none, 01 write, 10 set, 11 clear.
- `csr` in 12: CSR address.
- `wd` in XLEN: write/set/clear operand.
- `rd` out XLEN: combinational read of the addressed CSR, pre-update value.
- `irq` in NUM_IRQ: level-sensitive interrupt requests.
- `op_m` out 2: 11 = redirect PC to `addr_o` this cycle, else 00.
- `addr_o` out XLEN: redirect target; 0 when `op_m`=00.

## Operation
- CSR map: fflags 0x001, frm 0x002, fcsr 0x003, mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mcycle 0xB00, minstret 0xB02. Unmapped addresses read 0 and ignore writes.
- `mip[16+i]` is a register sampled from `irq[i]` every cycle.
- Detection, highest priority first:
  - pc > ROM_LIMIT: cause 0.
  - Opcode not in {3,19,35,51,99,111,115}: cause 2.
  - instr==0x00100073 (EBREAK): cause 3.
  - instr==0x00000073 (ECALL): cause 11.
  - Load/store limit: cause 4/6.
  - Interrupt, if mstatus.MIE and `mip & mie` is nonzero: lowest index i wins, cause = 0x8000_0000 | (16+i).
- Trap entry, at the edge ending cycle N:
  - mepc <= pc; mcause <= cause.
  - MPIE <= MIE; MIE <= 0.
  - Target = mtvec base (bits [1:0] cleared). If mtvec[1:0]==01 and the cause is an interrupt, target = base + 4*(16+i).
- MRET (instr==0x30200073): MIE <= MPIE; MPIE <= 1; target = mepc.
- FSM with two states:
  - RUN: a trap or MRET in the current cycle moves the FSM to REDIRECT and latches the target.
  - REDIRECT: `op_m`=11 and `addr_o`=target for exactly one cycle, then back to RUN. Detection is masked in REDIRECT because the flushed `instr` is not architectural.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when `retire` is high and no trap is taken that cycle.
  - A software write to a counter overrides its increment in the same cycle.

## Timing
- Reset values:
  - All CSRs 0, except mtvec = MTVEC_RESET.
  - mip = 0; FSM in RUN; `op_m`=00; `addr_o`=0.
- Trap latency: the cause is detected in cycle N, CSRs update at the end of N, and the redirect is visible in cycle N+1.
- A CSR write coinciding with a trap is dropped; the trap updates win.
- A CSR write to mstatus coinciding with MRET is also dropped.
- An interrupt raised while MIE=0 stays pending and is taken in the first RUN cycle after MIE becomes 1.
- Asserting `rst` mid-REDIRECT returns the FSM to RUN immediately and clears `op_m`.
- mcycle/minstret wrap from all-ones to 0 silently.

## Structure
- Shared package `csr_pkg`: CSR address constants, cause codes, `csr_op` encodings, SYSTEM instruction encodings, FSM state type.
- Sub-module `csr_irq_prio`: masks `mip & mie` and priority-encodes it to a valid flag and an index.

## Test plan
- Reset, then read mtvec with MTVEC_RESET=0x40 -> `rd`=0x40, `op_m`=00, mcycle increments by 1 per cycle.
- CSRRS on mie with wd=0x10000, then CSRRC with wd=0x10000 -> mie reads 0x10000, then 0.
- instr=0xFFFFFFFF at pc=0x20 -> next cycle `op_m`=11 for exactly one cycle, `addr_o`=mtvec, mepc=0x20, mcause=2, MIE cleared.
- mstatus.MIE=1, mie=0x30000, irq=0b0011, mtvec=0x81 -> cause 0x80000010, `addr_o`=0xC0; then MRET -> `addr_o`=mepc, MIE=1.
- ECALL issued in the same cycle as a CSRRW to mscratch -> mcause=11, mscratch unchanged, minstret not incremented.
- `rst` asserted during the REDIRECT cycle -> `op_m`=00 immediately; all CSRs at reset values.
